mult8x8_accurate: RTL and testbench

MULT8X8_ACCURATE -- requirements
Module: mult8x8_accurate

---
 rtl/mult8x8_accurate_pkg.sv | 5 +
 rtl/full_adder.sv | 11 +
 rtl/mult8x8_accurate.sv | 93 +++++++++
 tb/tb_mult8x8_accurate.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mult8x8_accurate_pkg.sv
// Shared widths for the exact 8x8 unsigned multiplier.
package mult8x8_accurate_pkg;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the reduction tree and final adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/mult8x8_accurate.sv
// Exact 8x8 unsigned multiplier: AND partial products, Wallace 3:2 tree,
// ripple carry-propagate adder, plus a one-cycle registered copy.
module mult8x8_accurate
    import mult8x8_accurate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    input  logic              in_valid,
    output logic [PROD_W-1:0] P,
    output logic [PROD_W-1:0] P_reg,
    output logic              out_valid
);
    localparam int NCSA = 6;

    logic [PROD_W-1:0] pp    [OP_W];
    logic [PROD_W-1:0] csa_x [NCSA];
    logic [PROD_W-1:0] csa_y [NCSA];
    logic [PROD_W-1:0] csa_z [NCSA];
    logic [PROD_W-1:0] csa_s [NCSA];
    logic [PROD_W-1:0] csa_c [NCSA];
    logic [PROD_W-1:0] cpa_c;

    logic [PROD_W-1:0] p_reg_q, p_reg_d;
    logic              out_valid_q, out_valid_d;

    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign pp[i] = {{OP_W{1'b0}}, A & {OP_W{B[i]}}} << i;
    end

    // Rows 8 -> 6 -> 4 -> 3 -> 2; the product fits in 16 bits, so carries
    // leaving bit 15 are always zero and are not kept.
    assign csa_x[0] = pp[0];    assign csa_y[0] = pp[1];    assign csa_z[0] = pp[2];
    assign csa_x[1] = pp[3];    assign csa_y[1] = pp[4];    assign csa_z[1] = pp[5];
    assign csa_x[2] = csa_s[0]; assign csa_y[2] = csa_c[0]; assign csa_z[2] = csa_s[1];
    assign csa_x[3] = csa_c[1]; assign csa_y[3] = pp[6];    assign csa_z[3] = pp[7];
    assign csa_x[4] = csa_s[2]; assign csa_y[4] = csa_c[2]; assign csa_z[4] = csa_s[3];
    assign csa_x[5] = csa_s[4]; assign csa_y[5] = csa_c[4]; assign csa_z[5] = csa_c[3];

    for (genvar k = 0; k < NCSA; k++) begin : g_csa
        assign csa_c[k][0] = 1'b0;
        for (genvar b = 0; b < PROD_W; b++) begin : g_bit
            if (b < PROD_W - 1) begin : g_fa
                full_adder u_fa (
                    .a    (csa_x[k][b]),
                    .b    (csa_y[k][b]),
                    .cin  (csa_z[k][b]),
                    .s    (csa_s[k][b]),
                    .cout (csa_c[k][b+1])
                );
            end else begin : g_top
                assign csa_s[k][b] = csa_x[k][b] ^ csa_y[k][b] ^ csa_z[k][b];
            end
        end
    end

    assign cpa_c[0] = 1'b0;
    for (genvar b = 0; b < PROD_W; b++) begin : g_cpa
        if (b < PROD_W - 1) begin : g_fa
            full_adder u_fa (
                .a    (csa_s[NCSA-1][b]),
                .b    (csa_c[NCSA-1][b]),
                .cin  (cpa_c[b]),
                .s    (P[b]),
                .cout (cpa_c[b+1])
            );
        end else begin : g_top
            assign P[b] = csa_s[NCSA-1][b] ^ csa_c[NCSA-1][b] ^ cpa_c[b];
        end
    end

    always_comb begin
        p_reg_d     = p_reg_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_reg_d = P;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_reg_q     <= p_reg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P_reg     = p_reg_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mult8x8_accurate.sv
// Directed and swept checks of the combinational and registered products.
module tb_mult8x8_accurate;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  A, B;
    logic        in_valid;
    logic [15:0] P, P_reg;
    logic        out_valid;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb [$];
    logic [15:0] last_p;

    mult8x8_accurate dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .P         (P),
        .P_reg     (P_reg),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic comb(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string tag);
        A = a;
        B = b;
        #10;
        chk(tag, {16'd0, P}, {16'd0, exp});
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r;
        in_valid = v;
        A = a;
        B = b;
        if (v && !r) sb.push_back(16'(int'(a) * int'(b)));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag);
        logic [15:0] e;
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            e = 16'hxxxx;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_preg"}, {16'd0, P_reg}, {16'd0, e});
        last_p = e;
    endtask

    initial begin
        int errs;
        logic [15:0] bad_a, bad_b;
        rst = 1'b1;
        in_valid = 1'b0;
        A = 8'd0;
        B = 8'd0;
        last_p = 16'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_preg", {16'd0, P_reg}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;

        comb(8'd0,   8'd0,   16'd0,     "p_0x0");
        comb(8'd255, 8'd1,   16'd255,   "p_255x1");
        comb(8'd12,  8'd15,  16'd180,   "p_12x15");
        comb(8'd100, 8'd200, 16'd20000, "p_100x200");
        comb(8'd50,  8'd5,   16'd250,   "p_50x5");
        comb(8'd128, 8'd128, 16'h4000,  "p_128x128");
        comb(8'd255, 8'd255, 16'hFE01,  "p_255x255");
        comb(8'd0,   8'd173, 16'd0,     "p_0xb");
        comb(8'd1,   8'd201, 16'd201,   "p_1xb");
        comb(8'd170, 8'd85,  16'd14450, "p_aax55");

        drive(1'b0, 1'b1, 8'd100, 8'd200);
        expect_out("load");
        drive(1'b0, 1'b0, 8'd7, 8'd9);
        chk("hold_preg", {16'd0, P_reg}, {16'd0, last_p});
        chk("hold_ov", {31'd0, out_valid}, 32'd0);

        drive(1'b1, 1'b1, 8'd255, 8'd255);
        chk("rstov_preg", {16'd0, P_reg}, 32'd0);
        chk("rstov_ov", {31'd0, out_valid}, 32'd0);
        chk("rstov_p", {16'd0, P}, 32'd65025);

        drive(1'b0, 1'b1, 8'd3, 8'd7);
        expect_out("b2b0");
        drive(1'b0, 1'b1, 8'd9, 8'd9);
        expect_out("b2b1");
        drive(1'b0, 1'b1, 8'd0, 8'd255);
        expect_out("b2b2");

        drive(1'b0, 1'b1, 8'd11, 8'd13);
        drive(1'b1, 1'b1, 8'd17, 8'd19);
        void'(sb.pop_front());
        chk("mid_rst_preg", {16'd0, P_reg}, 32'd0);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 1'b0, 8'd4, 8'd4);
        chk("rel_ov", {31'd0, out_valid}, 32'd0);
        chk("rel_preg", {16'd0, P_reg}, 32'd0);
        last_p = 16'd0;
        drive(1'b0, 1'b1, 8'd21, 8'd23);
        expect_out("rel_first");

        for (int i = 0; i < 150; i++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            drive(1'b0, v, 8'($urandom), 8'($urandom));
            if (v) begin
                expect_out("rnd");
            end else begin
                chk("rnd_hold_ov", {31'd0, out_valid}, 32'd0);
                chk("rnd_hold_preg", {16'd0, P_reg}, {16'd0, last_p});
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        errs = 0;
        bad_a = 16'd0;
        bad_b = 16'd0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                A = 8'(a);
                B = 8'(b);
                #1;
                if (P !== 16'(a * b)) begin
                    if (errs == 0) begin
                        bad_a = 16'(a);
                        bad_b = 16'(b);
                    end
                    errs++;
                end
            end
        end
        chk("sweep_errs", errs, 32'd0);
        if (errs != 0) $display("first bad pair a=%0d b=%0d", bad_a, bad_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
